// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code stage: flag packing order,
// branch condition encodings and the packed flag type.
package cc_pkg;

    // Packed flag order is {N, Z, V, C}
    typedef logic [3:0] flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    function automatic flags_t pack_flags(input logic n, input logic z,
                                          input logic v, input logic c);
        flags_t f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational branch-condition evaluator: maps a 4-bit condition select
// and the N/Z/V/C flags to a taken/not-taken decision.
module cc_cond_eval
    import cc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       v,
    input  logic       c,
    output logic       taken
);

    logic ge;

    // Signed comparisons derive from N xor V
    assign ge = (n == v);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = ge;
            COND_LT: taken = ~ge;
            COND_GT: taken = ~z & ge;
            COND_LE: taken = z | ~ge;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_flag_unit.sv
// Condition-code register with carry feedback, branch evaluation and a LIFO
// shadow stack for interrupt entry/exit. Define CC_BYPASS_EN to forward *_in.
module cc_flag_unit
    import cc_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Z_in,
    input  logic       V_in,
    input  logic       C_in,
    input  logic       N_in,
    input  logic       CC_WE,
    input  logic       SET_C,
    input  logic       CLR_C,
    input  logic       PUSH,
    input  logic       POP,
    input  logic [3:0] COND,
    output logic       Z,
    output logic       V,
    output logic       C,
    output logic       N,
    output logic       Pre_C,
    output logic       TAKEN,
    output logic       FULL,
    output logic       EMPTY,
    output logic       STK_ERR
);

    localparam int IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(STACK_DEPTH);

    flags_t           flags_q;
    flags_t           flags_next;
    flags_t           in_flags;
    flags_t           eval_flags;
    flags_t           stk_top;
    flags_t           stk [STACK_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_next;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             err_q;
    logic             is_empty;
    logic             is_full;
    logic             pop_ok;
    logic             push_ok;
    logic             swap_ok;
    logic             stk_we;
    logic             err_set;

    assign in_flags = pack_flags(N_in, Z_in, V_in, C_in);

    assign is_empty = (ptr_q == '0);
    assign is_full  = (ptr_q == DEPTH_PTR);
    assign top_idx  = ptr_q[IDX_W-1:0] - IDX_W'(1);
    assign stk_top  = stk[top_idx];

    // A simultaneous PUSH+POP is a swap of the top entry; on an empty stack
    // it degrades to a plain POP underflow and nothing is written.
    assign pop_ok  = POP & ~is_empty;
    assign swap_ok = POP & PUSH & ~is_empty;
    assign push_ok = PUSH & ~POP & ~is_full;
    assign stk_we  = push_ok | swap_ok;
    assign wr_idx  = swap_ok ? top_idx : ptr_q[IDX_W-1:0];
    assign err_set = (PUSH & ~POP & is_full) | (POP & is_empty);

    always_comb begin
        flags_next = flags_q;
        if (pop_ok) begin
            flags_next = stk_top;
        end else if (CC_WE) begin
            flags_next = in_flags;
        end else if (SET_C && !CLR_C) begin
            flags_next[FLAG_C] = 1'b1;
        end else if (CLR_C && !SET_C) begin
            flags_next[FLAG_C] = 1'b0;
        end
    end

    always_comb begin
        ptr_next = ptr_q;
        if (push_ok) begin
            ptr_next = ptr_q + PTR_W'(1);
        end else if (pop_ok && !swap_ok) begin
            ptr_next = ptr_q - PTR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_next;
            ptr_q   <= ptr_next;
            err_q   <= err_q | err_set;
        end
    end

    // Snapshot storage is data only; its contents are meaningless at reset.
    always_ff @(posedge CLK) begin
        if (!RST && stk_we) begin
            stk[wr_idx] <= flags_q;
        end
    end

`ifdef CC_BYPASS_EN
    // Forward the incoming flags so compare-and-branch and ADC chains see
    // them in the same cycle; a valid POP overrides the write, so no forward.
    assign eval_flags = (CC_WE && !pop_ok) ? in_flags : flags_q;
`else
    assign eval_flags = flags_q;
`endif

    cc_cond_eval u_cond_eval (
        .cond  (COND),
        .n     (eval_flags[FLAG_N]),
        .z     (eval_flags[FLAG_Z]),
        .v     (eval_flags[FLAG_V]),
        .c     (eval_flags[FLAG_C]),
        .taken (TAKEN)
    );

    assign Z       = flags_q[FLAG_Z];
    assign V       = flags_q[FLAG_V];
    assign C       = flags_q[FLAG_C];
    assign N       = flags_q[FLAG_N];
    assign Pre_C   = eval_flags[FLAG_C];
    assign FULL    = is_full;
    assign EMPTY   = is_empty;
    assign STK_ERR = err_q;

endmodule

// File: tb/tb_cc_flag_unit.sv
// Directed self-checking bench for cc_flag_unit (default STACK_DEPTH=4).
module tb_cc_flag_unit;

    logic       CLK;
    logic       RST;
    logic       Z_in, V_in, C_in, N_in;
    logic       CC_WE, SET_C, CLR_C, PUSH, POP;
    logic [3:0] COND;
    logic       Z, V, C, N, Pre_C, TAKEN, FULL, EMPTY, STK_ERR;

    int checks   = 0;
    int failures = 0;

    cc_flag_unit #(.STACK_DEPTH(4), .PTR_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .Z_in(Z_in), .V_in(V_in), .C_in(C_in), .N_in(N_in),
        .CC_WE(CC_WE), .SET_C(SET_C), .CLR_C(CLR_C),
        .PUSH(PUSH), .POP(POP), .COND(COND),
        .Z(Z), .V(V), .C(C), .N(N), .Pre_C(Pre_C), .TAKEN(TAKEN),
        .FULL(FULL), .EMPTY(EMPTY), .STK_ERR(STK_ERR)
    );

    initial CLK = 1'b0;
    always #20 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CC_WE = 0; SET_C = 0; CLR_C = 0; PUSH = 0; POP = 0;
    endtask

    task automatic set_in(input logic [3:0] f);
        {N_in, Z_in, V_in, C_in} = f;
    endtask

    task automatic load(input logic [3:0] f);
        set_in(f);
        CC_WE = 1;
        step();
        idle();
    endtask

    task automatic chk_table(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 16; i++) begin
            COND = 4'(i);
            #1;
            chk($sformatf("%s_cond%0d", tag, i), TAKEN, exp[i]);
        end
    endtask

    task automatic do_reset();
        idle();
        RST = 1;
        step();
        step();
        RST = 0;
    endtask

    initial begin
        RST = 0; COND = 0;
        set_in(4'b0000);
        idle();
        do_reset();

        // Reset state
        chk("rst_flags", {N, Z, V, C}, 4'b0000);
        chk("rst_prec", Pre_C, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_err", STK_ERR, 0);
        chk_table("tbl_0000", 16'h2D55);

        // SUB 0x1234-0x1234: Z=1, C=1; check bypass/latency in the write cycle
        COND = 4'd1;
        set_in(4'b0101);
        CC_WE = 1;
        #1;
`ifdef CC_BYPASS_EN
        chk("byp_taken_same", TAKEN, 1);
        chk("byp_prec_same", Pre_C, 1);
`else
        chk("byp_taken_same", TAKEN, 0);
        chk("byp_prec_same", Pre_C, 0);
`endif
        step();
        idle();
        COND = 4'd1;
        #1;
        chk("sub_taken_next", TAKEN, 1);
        chk("sub_flags", {N, Z, V, C}, 4'b0101);
        chk("sub_prec", Pre_C, 1);
        COND = 4'd2; #1; chk("sub_ne", TAKEN, 0);
        COND = 4'd9; #1; chk("sub_hi", TAKEN, 0);
        chk_table("tbl_0101", 16'h4D4B);

        // N=1, V=0: LT taken, GE not
        load(4'b1000);
        COND = 4'd12; #1; chk("lt_taken", TAKEN, 1);
        COND = 4'd11; #1; chk("ge_taken", TAKEN, 0);
        chk_table("tbl_1000", 16'h5535);
        SET_C = 1; step(); idle();
        chk("sec_flags", {N, Z, V, C}, 4'b1001);
        SET_C = 1; CLR_C = 1; step(); idle();
        chk("secclc_c", C, 1);
        CLR_C = 1; step(); idle();
        chk("clc_c", C, 0);
        chk("clc_prec", Pre_C, 0);
        chk("clc_n", N, 1);
        CC_WE = 1; set_in(4'b0110); SET_C = 1; step(); idle();
        chk("we_over_sec", {N, Z, V, C}, 4'b0110);

        // PUSH with simultaneous CC_WE saves the pre-update flags
        load(4'b1010);
        chk("ld_1010", {N, Z, V, C}, 4'b1010);
        chk_table("tbl_1010", 16'h2CB5);
        PUSH = 1; CC_WE = 1; set_in(4'b0101); step(); idle();
        chk("push_we_flags", {N, Z, V, C}, 4'b0101);
        chk("push_empty", EMPTY, 0);
        POP = 1; CC_WE = 1; set_in(4'b1111); step(); idle();
        chk("pop_flags", {N, Z, V, C}, 4'b1010);
        chk("pop_empty", EMPTY, 1);
        chk("pop_err", STK_ERR, 0);

        // Fill the stack with distinct snapshots
        load(4'b0001);
        PUSH = 1; CC_WE = 1;
        set_in(4'b0010); step();
        set_in(4'b0100); step();
        chk("fill_notfull", FULL, 0);
        set_in(4'b1000); step();
        set_in(4'b0011); step();
        idle();
        chk("fill_full", FULL, 1);
        chk("fill_err0", STK_ERR, 0);
        chk("fill_flags", {N, Z, V, C}, 4'b0011);
        PUSH = 1; step(); idle();
        chk("ovf_err", STK_ERR, 1);
        chk("ovf_full", FULL, 1);
        chk("ovf_flags", {N, Z, V, C}, 4'b0011);
        // Swap: top (1000) comes back, current (0011) takes its place
        PUSH = 1; POP = 1; step(); idle();
        chk("swap_flags", {N, Z, V, C}, 4'b1000);
        chk("swap_full", FULL, 1);
        POP = 1;
        step(); chk("pop1", {N, Z, V, C}, 4'b0011);
        chk("pop1_full", FULL, 0);
        step(); chk("pop2", {N, Z, V, C}, 4'b0100);
        step(); chk("pop3", {N, Z, V, C}, 4'b0010);
        chk("pop3_empty", EMPTY, 0);
        step(); chk("pop4", {N, Z, V, C}, 4'b0001);
        idle();
        chk("pop4_empty", EMPTY, 1);
        chk("err_sticky", STK_ERR, 1);

        // Underflow from reset
        do_reset();
        chk("rst2_err", STK_ERR, 0);
        POP = 1; step(); idle();
        chk("unf_err", STK_ERR, 1);
        chk("unf_flags", {N, Z, V, C}, 4'b0000);
        chk("unf_empty", EMPTY, 1);
        POP = 1; CC_WE = 1; set_in(4'b0100); step(); idle();
        chk("unf_we_flags", {N, Z, V, C}, 4'b0100);
        do_reset();
        PUSH = 1; POP = 1; step(); idle();
        chk("swap_empty_err", STK_ERR, 1);
        chk("swap_empty_empty", EMPTY, 1);
        chk("swap_empty_flags", {N, Z, V, C}, 4'b0000);

        // Reset wins over concurrent activity
        load(4'b1111);
        RST = 1; PUSH = 1; CC_WE = 1; set_in(4'b1111); step();
        RST = 0; idle();
        chk("rstwin_flags", {N, Z, V, C}, 4'b0000);
        chk("rstwin_empty", EMPTY, 1);
        chk("rstwin_err", STK_ERR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cc_flag_unit.md
Name: cc_flag_unit

Overview:
- Condition-code stage directly downstream of the ALU/flag generator.
- Registers the Z/V/C/N flags on each flag-writing instruction.
- Feeds the registered carry back to the ALU as Pre_C for ADC/SBB.
- Evaluates a 4-bit branch condition, and provides a small LIFO shadow stack so flags survive interrupt entry/exit.

Parameters:
- STACK_DEPTH, 4: number of 4-bit flag snapshots held in the shadow stack; power of two, minimum 2.
- PTR_W, 3: stack-pointer width; must equal log2(STACK_DEPTH)+1 so that full and empty are distinguishable.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- Z_in, V_in, C_in, N_in  in  1 each  flags from the ALU for the current instruction.
- CC_WE  in  1  load the *_in flags at the next edge.
- SET_C  in  1  force C=1 (instruction SEC).
- CLR_C  in  1  force C=0 (instruction CLC).
- PUSH  in  1  save the current registered flags to the stack.
- POP  in  1  restore flags from the top of the stack.
- COND  in  4  branch condition select.
- Z, V, C, N  out  1 each  registered flags.
- Pre_C  out  1  carry-in to the ALU; equals registered C.
- TAKEN  out  1  combinational result of COND against the flags.
- FULL  out  1  stack holds STACK_DEPTH entries.
- EMPTY  out  1  stack holds 0 entries.
- STK_ERR  out  1  sticky error: overflow or underflow attempted.

Behaviour:
- Clocking and reset: one clock (CLK); reset RST is synchronous and active-high.
- Reset values:
  - Z=V=C=N=0, Pre_C=0.
  - Stack pointer=0, so EMPTY=1 and FULL=0.
  - STK_ERR=0.
  - Stack contents are don't-care.
- All state updates on the rising edge of CLK. Flag latency: *_in sampled with CC_WE appears on Z/V/C/N one cycle later.
- Flag next-state priority, highest first:
  - Valid POP: flags <= stack[top].
  - CC_WE: flags <= {N_in, Z_in, V_in, C_in}.
  - SET_C: C <= 1, other flags hold.
  - CLR_C: C <= 0, other flags hold.
  - Otherwise hold.
  - SET_C and CLR_C together: C holds.
- PUSH alone:
  - If not FULL: stack[ptr] <= current registered flags (the pre-update value, even if CC_WE is asserted the same cycle); ptr+1.
  - If FULL: no write, ptr holds, STK_ERR <= 1.
- POP alone:
  - If not EMPTY: ptr-1, flags loaded from the top entry.
  - If EMPTY: flags follow the normal CC_WE/SET/CLR rules, ptr holds, STK_ERR <= 1.
- PUSH and POP in the same cycle (swap):
  - If not EMPTY: top entry <= current flags, flags <= old top entry, ptr unchanged.
  - If EMPTY: treated as POP underflow; no push occurs; STK_ERR <= 1.
- STK_ERR clears only on RST.
- Carry convention: C=1 after subtraction means no borrow, consistent with the ALU SUB/SBB output.
- TAKEN encoding (combinational on registered flags):
  - 0 always; 1 EQ Z; 2 NE !Z; 3 CS C; 4 CC !C.
  - 5 MI N; 6 PL !N; 7 VS V; 8 VC !V.
  - 9 HI C&!Z; 10 LS !C|Z.
  - 11 GE N==V; 12 LT N!=V; 13 GT !Z&(N==V); 14 LE Z|(N!=V).
  - 15 never.
- RST asserted in the same cycle as PUSH/POP/CC_WE: reset wins; all state returns to reset values.

Optional Feature:
- Macro: CC_BYPASS_EN.
- Defined: while CC_WE=1 (and no valid POP), TAKEN and Pre_C are evaluated on the *_in flags instead of the registered flags. This gives same-cycle compare-and-branch and back-to-back ADC chains. Registered outputs Z/V/C/N are unchanged.
- Undefined: TAKEN and Pre_C always use the registered flags, giving one cycle of latency after a flag write.

Decomposition:
- Package cc_pkg holds:
  - COND encodings as named 4-bit constants (COND_AL, COND_EQ … COND_NV).
  - Flag bit-index constants for the packed order {N,Z,V,C}: FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0.
  - A 4-bit flags typedef.
- Sub-module cc_cond_eval: purely combinational; takes COND plus four flags, returns TAKEN.
- cc_flag_unit contains the flag register, stack array and pointer, instantiates cc_cond_eval once, and implements the bypass mux under CC_BYPASS_EN.

Test Plan:
- Reset, then ALU result A=0x1234, B=0x1234, SUB: Z_in=1, C_in=1, V_in=0, N_in=0, CC_WE=1 → next cycle Z=1, C=1, Pre_C=1; COND=1 gives TAKEN=1; COND=2 gives TAKEN=0; COND=9 gives TAKEN=0.
- Flags N=1, V=0 loaded → COND=12 gives TAKEN=1, COND=11 gives TAKEN=0. Then SET_C and CLR_C asserted together → C unchanged; CLR_C alone → C=0, Pre_C=0.
- Flags 4'b1010 (N=1, V=1) loaded; PUSH with CC_WE loading 4'b0101 (Z=1, C=1) → stack top=4'b1010, flags=4'b0101. POP → flags=4'b1010, EMPTY=1.
- PUSH 4 times with STACK_DEPTH=4 → FULL=1. 5th PUSH → ptr unchanged, STK_ERR=1. POP 4 times → EMPTY=1; entries return in reverse order.
- From reset, POP → STK_ERR=1, flags unchanged at 0. PUSH+POP while EMPTY → STK_ERR=1, ptr=0.
- With CC_BYPASS_EN defined: CC_WE=1, Z_in=1, COND=1 → TAKEN=1 in the same cycle. Without the macro → TAKEN=0 in that cycle and 1 in the following cycle.
